// File: rtl/shift_iter.sv
// shift_iter: a multi-cycle shift/rotate engine.
// A request (operation, 5-bit count, carry, operand) is accepted over a
// valid/ready handshake. The count is then retired in STEP-bit chunks while
// the remaining count is at least STEP, and in 1-bit chunks after that. The
// result is returned over a second valid/ready handshake. This trades shift
// latency for a much smaller shifter than a full 32-bit barrel shifter.

package shifterPkg;
    // Operation select. Encoding 3'd7 is unused and is handled as a pass-through.
    typedef enum logic [2:0] {
        SHL = 3'd0,
        SHR = 3'd1,
        SAR = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4,
        RCL = 3'd5,
        RCR = 3'd6
    } shiftOpSel;
endpackage

module shift_iter #(
    parameter int STEP = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inValid,
    output logic                  inReady,
    input  shifterPkg::shiftOpSel shiftOp,
    input  logic [4:0]            count,
    input  logic                  carryIn,
    input  logic [31:0]           dataIn,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [31:0]           dataOut,
    output logic                  carryOut,
    output logic                  zero,
    output logic                  busy
);
    import shifterPkg::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT       r_state;
    shiftOpSel   r_op;
    logic [31:0] r_data;
    logic        r_carry;
    logic [4:0]  r_remaining;
    logic        r_outValid;
    logic        r_inReady;
    logic        r_busy;
    logic        r_zero;

    logic        w_opLegal;
    logic [3:0]  w_stepAmt;
    logic [5:0]  w_n;
    logic [32:0] w_wide;
    logic [32:0] w_rc;
    logic [32:0] w_rot;
    logic [31:0] w_stepData;
    logic        w_stepCarry;

    // Decide whether the incoming operation is a real shift or the unused encoding.
    always_comb begin
        w_opLegal = 1'b0;
        case (shiftOp)
            SHL, SHR, SAR, ROL, ROR, RCL, RCR: w_opLegal = 1'b1;
            default:                           w_opLegal = 1'b0;
        endcase
    end

    // One iteration of the current operation: a STEP-bit step while enough count remains, otherwise a single bit.
    always_comb begin
        w_stepAmt   = (r_remaining >= 5'(STEP)) ? 4'(STEP) : 4'd1;
        w_n         = 6'(w_stepAmt);
        w_wide      = '0;
        w_rc        = {r_carry, r_data};
        w_rot       = '0;
        w_stepData  = r_data;
        w_stepCarry = r_carry;
        case (r_op)
            SHL: begin
                w_wide      = {1'b0, r_data} << w_n;
                w_stepData  = w_wide[31:0];
                w_stepCarry = w_wide[32];
            end
            SHR: begin
                w_wide      = {r_data, 1'b0} >> w_n;
                w_stepData  = w_wide[32:1];
                w_stepCarry = w_wide[0];
            end
            SAR: begin
                w_wide      = $signed({r_data, 1'b0}) >>> w_n;
                w_stepData  = w_wide[32:1];
                w_stepCarry = w_wide[0];
            end
            ROL: begin
                w_stepData  = (r_data << w_n) | (r_data >> (6'd32 - w_n));
                w_stepCarry = w_stepData[0];
            end
            ROR: begin
                w_stepData  = (r_data >> w_n) | (r_data << (6'd32 - w_n));
                w_stepCarry = w_stepData[31];
            end
            RCL: begin
                w_rot       = (w_rc << w_n) | (w_rc >> (6'd33 - w_n));
                w_stepData  = w_rot[31:0];
                w_stepCarry = w_rot[32];
            end
            RCR: begin
                w_rot       = (w_rc >> w_n) | (w_rc << (6'd33 - w_n));
                w_stepData  = w_rot[31:0];
                w_stepCarry = w_rot[32];
            end
            default: begin
                w_stepData  = r_data;
                w_stepCarry = r_carry;
            end
        endcase
    end

    // Control FSM: accept in IDLE, iterate in RUN, present and hold the result in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= SHL;
            r_data      <= '0;
            r_carry     <= 1'b0;
            r_remaining <= '0;
            r_outValid  <= 1'b0;
            r_inReady   <= 1'b1;
            r_busy      <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (inValid) begin
                        r_op        <= shiftOp;
                        r_data      <= dataIn;
                        r_carry     <= carryIn;
                        r_remaining <= count;
                        r_inReady   <= 1'b0;
                        r_busy      <= 1'b1;
                        if (count == 5'd0 || !w_opLegal) begin
                            r_state    <= DONE;
                            r_outValid <= 1'b1;
                            r_zero     <= (dataIn == 32'd0);
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_data      <= w_stepData;
                    r_carry     <= w_stepCarry;
                    r_remaining <= r_remaining - 5'(w_stepAmt);
                    if (r_remaining == 5'(w_stepAmt)) begin
                        r_state    <= DONE;
                        r_outValid <= 1'b1;
                        r_zero     <= (w_stepData == 32'd0);
                    end
                end
                DONE: begin
                    if (outReady) begin
                        r_state    <= IDLE;
                        r_outValid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_inReady  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_outValid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_inReady  <= 1'b1;
                end
            endcase
        end
    end

    assign inReady  = r_inReady;
    assign outValid = r_outValid;
    assign busy     = r_busy;
    assign dataOut  = r_data;
    assign carryOut = r_carry;
    assign zero     = r_zero;

endmodule

// File: tb/tb_shift_iter.sv
// tb_shift_iter: self-checking bench for shift_iter.
// Every result is predicted by a one-shot, full-count reference of each
// operation and compared against the iterative engine, together with the
// handshake latency, backpressure hold and asynchronous reset behaviour.

module tb_shift_iter;
    import shifterPkg::*;

    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        inReady;
    shiftOpSel   shiftOp;
    logic [4:0]  count;
    logic        carryIn;
    logic [31:0] dataIn;
    logic        outValid;
    logic        outReady;
    logic [31:0] dataOut;
    logic        carryOut;
    logic        zero;
    logic        busy;

    int checkCount = 0;
    int errorCount = 0;

    shift_iter #(.STEP(STEP)) dut (
        .clk      (clk),
        .reset    (reset),
        .inValid  (inValid),
        .inReady  (inReady),
        .shiftOp  (shiftOp),
        .count    (count),
        .carryIn  (carryIn),
        .dataIn   (dataIn),
        .outValid (outValid),
        .outReady (outReady),
        .dataOut  (dataOut),
        .carryOut (carryOut),
        .zero     (zero),
        .busy     (busy)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference: the whole count-bit operation done at once on doubled words, plus the latency formula.
    task automatic predictResult(input logic [2:0] opBits, input logic [31:0] d, input logic c,
                                 input logic [4:0] n, output logic [31:0] r, output logic co,
                                 output int lat);
        logic [63:0]        w;
        logic signed [63:0] s;
        logic [65:0]        v;
        int                 k;
        k   = int'(n);
        r   = d;
        co  = c;
        lat = 1;
        if (k != 0 && opBits != 3'd7) begin
            lat = 1 + k / STEP + k % STEP;
            case (opBits)
                3'd0: begin w = {32'h0, d} << k; r = w[31:0];  co = w[32]; end
                3'd1: begin w = {d, 32'h0} >> k; r = w[63:32]; co = w[31]; end
                3'd2: begin s = {d, 32'h0}; s = s >>> k; r = s[63:32]; co = s[31]; end
                3'd3: begin w = {d, d} << k; r = w[63:32]; co = r[0]; end
                3'd4: begin w = {d, d} >> k; r = w[31:0];  co = r[31]; end
                3'd5: begin v = {c, d, c, d} << k; r = v[64:33]; co = v[65]; end
                default: begin v = {c, d, c, d} >> k; r = v[31:0]; co = v[32]; end
            endcase
        end
    endtask

    // One full transaction, entered and left on a falling edge: request, latency, result, backpressure, release.
    task automatic applyStimulus(input logic [2:0] opBits, input logic [31:0] data, input logic cin,
                                 input logic [4:0] cnt, input int holdCycles, input bit pokeWhileBusy);
        logic [31:0] expData;
        logic        expCarry;
        int          expLat;
        int          lat;
        predictResult(opBits, data, cin, cnt, expData, expCarry, expLat);
        checkOutput("inReady before request", 64'(inReady), 64'd1);
        inValid = 1'b1;
        shiftOp = shiftOpSel'(opBits);
        dataIn  = data;
        carryIn = cin;
        count   = cnt;
        @(negedge clk);
        inValid = 1'b0;
        dataIn  = $urandom;
        carryIn = ~cin;
        count   = 5'($urandom_range(0, 31));
        lat = 1;
        while (!outValid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'(expLat));
        checkOutput("dataOut", 64'(dataOut), 64'(expData));
        checkOutput("carryOut", 64'(carryOut), 64'(expCarry));
        checkOutput("zero", 64'(zero), 64'(expData == 32'd0));
        checkOutput("inReady while done", 64'(inReady), 64'd0);
        checkOutput("busy while done", 64'(busy), 64'd1);
        for (int i = 0; i < holdCycles; i++) begin
            if (pokeWhileBusy) begin
                inValid = 1'b1;
                dataIn  = ~data;
                count   = 5'd3;
            end
            @(negedge clk);
            inValid = 1'b0;
            checkOutput("hold outValid", 64'(outValid), 64'd1);
            checkOutput("hold dataOut", 64'(dataOut), 64'(expData));
            checkOutput("hold carryOut", 64'(carryOut), 64'(expCarry));
            checkOutput("hold inReady", 64'(inReady), 64'd0);
        end
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("release outValid", 64'(outValid), 64'd0);
        checkOutput("release inReady", 64'(inReady), 64'd1);
        checkOutput("release busy", 64'(busy), 64'd0);
    endtask

    // Main sequence: reset, directed cases, backpressure, resets mid-flight, then random traffic.
    initial begin
        logic [2:0]  opBits;
        logic [31:0] data;
        int          sawValid;
        int          sawBusy;

        reset    = 1'b1;
        inValid  = 1'b0;
        shiftOp  = SHL;
        count    = '0;
        carryIn  = 1'b0;
        dataIn   = '0;
        outReady = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset dataOut", 64'(dataOut), 64'd0);
        checkOutput("reset carryOut", 64'(carryOut), 64'd0);
        checkOutput("reset zero", 64'(zero), 64'd0);
        checkOutput("reset outValid", 64'(outValid), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset inReady", 64'(inReady), 64'd1);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(3'd0, 32'h80000001, 1'b0, 5'd1, 0, 1'b0);
        applyStimulus(3'd2, 32'h80000000, 1'b0, 5'd31, 0, 1'b0);
        applyStimulus(3'd4, 32'h12345678, 1'b0, 5'd8, 0, 1'b0);
        applyStimulus(3'd5, 32'h80000000, 1'b1, 5'd1, 0, 1'b0);
        applyStimulus(3'd6, 32'h00000001, 1'b0, 5'd1, 0, 1'b0);
        for (int op = 0; op < 8; op++) begin
            applyStimulus(3'(op), 32'hA5A5A5A5, 1'b1, 5'd0, 0, 1'b0);
        end
        applyStimulus(3'd7, 32'hDEADBEEF, 1'b0, 5'd13, 1, 1'b0);
        applyStimulus(3'd1, 32'hF0F0F0F0, 1'b1, 5'd9, 5, 1'b1);

        // After the poked backpressure run, nothing stale may appear.
        @(negedge clk);
        checkOutput("no stale result after poke", 64'(outValid), 64'd0);

        // Reset in the middle of a long SAR.
        inValid = 1'b1;
        shiftOp = SAR;
        dataIn  = 32'h80000000;
        count   = 5'd31;
        @(negedge clk);
        inValid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("busy mid run", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid-run reset outValid", 64'(outValid), 64'd0);
        checkOutput("mid-run reset busy", 64'(busy), 64'd0);
        checkOutput("mid-run reset inReady", 64'(inReady), 64'd1);
        checkOutput("mid-run reset dataOut", 64'(dataOut), 64'd0);
        @(negedge clk);
        reset    = 1'b0;
        outReady = 1'b1;
        sawValid = 0;
        sawBusy  = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (outValid) sawValid++;
            if (busy) sawBusy++;
        end
        outReady = 1'b0;
        checkOutput("stale outValid after reset", 64'(sawValid), 64'd0);
        checkOutput("stale busy after reset", 64'(sawBusy), 64'd0);

        // Reset while a result is being held.
        inValid = 1'b1;
        shiftOp = ROL;
        dataIn  = 32'h00000001;
        carryIn = 1'b1;
        count   = 5'd0;
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("done before reset", 64'(outValid), 64'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid-done reset outValid", 64'(outValid), 64'd0);
        checkOutput("mid-done reset carryOut", 64'(carryOut), 64'd0);
        checkOutput("mid-done reset dataOut", 64'(dataOut), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 200; t++) begin
            opBits = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       data = 32'd0;
                1:       data = 32'd1 << $urandom_range(0, 31);
                default: data = $urandom;
            endcase
            applyStimulus(opBits, data, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
